// File: rtl/ps2_keyboard_tx.sv
// PS/2 device-side (keyboard) transmitter: serialises handshaked bytes into 11-bit frames
// on self-driven ps2_clk/ps2_data. Optional macro PS2_TX_PARITY_INJECT_EN adds inject_err.
module ps2_keyboard_tx #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       resetn,
`ifdef PS2_TX_PARITY_INJECT_EN
  input  logic       inject_err,
`endif
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PH_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int unsigned PW     = $clog2(PH_MAX + 1);
  localparam logic [PW-1:0] HALF_LAST = PW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT  = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [10:0]   frame_q, frame_d;
  logic          clk_q, clk_d;
  logic          data_q, data_d;
  logic          done_q, done_d;
  logic          parity;

`ifdef PS2_TX_PARITY_INJECT_EN
  assign parity = ~(^in_data) ^ inject_err;
`else
  assign parity = ~(^in_data);
`endif

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_idx_q <= '0;
      frame_q   <= '1;
      clk_q     <= 1'b1;
      data_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      clk_q     <= clk_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    clk_d     = clk_q;
    data_d    = data_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          frame_d   = {1'b1, parity, in_data, 1'b0};
          data_d    = 1'b0;
          clk_d     = 1'b1;
          phase_d   = '0;
          bit_idx_d = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          if (clk_q) begin
            clk_d = 1'b0;
          end else if (bit_idx_q == LAST_BIT) begin
            clk_d     = 1'b1;
            data_d    = 1'b1;
            bit_idx_d = '0;
            state_d   = GAP;
          end else begin
            // Data changes only at the start of the high phase; frame_q[0] is the bit on the wire.
            clk_d     = 1'b1;
            frame_d   = {1'b1, frame_q[10:1]};
            data_d    = frame_q[1];
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign ps2_clk  = clk_q;
  assign ps2_data = data_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Self-checking bench for ps2_keyboard_tx: timing model compared every cycle, plus a
// behavioural host receiver and directed scenarios with literal expectations.
module tb_ps2_keyboard_tx;

  localparam int H   = 4;
  localparam int GAP = 8;
  localparam int P   = 22 * H + GAP + 1;  // cycle index of the done pulse after an accept

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       inject_err = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, ps2_clk, ps2_data, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;

  ps2_keyboard_tx #(.HALF_PERIOD(H), .GAP_CYCLES(GAP)) dut (
    .clk      (clk),
    .resetn   (resetn),
`ifdef PS2_TX_PARITY_INJECT_EN
    .inject_err(inject_err),
`endif
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Host receiver: samples data on ps2_clk falling edges, keeps every frame and valid bytes.
  logic [10:0] rx_sh = '1;
  int          rx_cnt = 0;
  logic [7:0]  rx_bytes[$];
  logic [10:0] rx_frames[$];

  always @(negedge ps2_clk or negedge resetn) begin
    if (!resetn) begin
      rx_cnt = 0;
    end else begin
      rx_sh[rx_cnt] = ps2_data;
      rx_cnt++;
      if (rx_cnt == 11) begin
        rx_frames.push_back(rx_sh);
        if (!rx_sh[0] && rx_sh[10] && ($countones(rx_sh[9:1]) % 2 == 1))
          rx_bytes.push_back(rx_sh[8:1]);
        rx_cnt = 0;
      end
    end
  end

  // Model: time since the accept edge determines every output.
  bit          m_ok = 1'b0;
  bit          m_active = 1'b0;
  bit          m_acc = 1'b0;
  int          m_t = 0;
  logic [10:0] m_word = '1;
  logic        s_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  task automatic model_step();
    logic par;
    m_acc = 1'b0;
    if (!resetn) begin
      m_active = 1'b0;
      m_t      = 0;
      m_ok     = 1'b1;
    end else if (m_ok) begin
      if ((!m_active || m_t == P) && in_valid) begin
        par      = ($countones(in_data) % 2 == 0) ^ inject_err;
        m_word   = {1'b1, par, in_data, 1'b0};
        m_active = 1'b1;
        m_t      = 1;
        m_acc    = 1'b1;
      end else if (m_active) begin
        m_t++;
        if (m_t > P) m_active = 1'b0;
      end
    end
  endtask

  task automatic compare();
    logic e_clk, e_data;
    int k, ph;
    e_clk  = 1'b1;
    e_data = 1'b1;
    if (m_active && m_t >= 1 && m_t <= 22 * H) begin
      k      = (m_t - 1) / (2 * H);
      ph     = (m_t - 1) % (2 * H);
      e_clk  = (ph < H);
      e_data = m_word[k];
    end
    check("ps2_clk",  {31'd0, ps2_clk},  {31'd0, e_clk});
    check("ps2_data", {31'd0, ps2_data}, {31'd0, e_data});
    check("busy",     {31'd0, busy},     {31'd0, m_active && m_t < P});
    check("done",     {31'd0, done},     {31'd0, m_active && m_t == P});
    check("in_ready", {31'd0, in_ready}, {31'd0, !m_active || m_t == P});
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic tick();
    @(negedge clk);
    ncyc++;
    s_done = done;
    if (m_ok) compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_accept(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_acc && n < 400);
    check({name, " accept"}, {31'd0, m_acc}, 32'd1);
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_done && n < 400);
    check({name, " done seen"}, {31'd0, s_done}, 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic inj, input string name, output int lat);
    int n;
    in_data    = d;
    inject_err = inj;
    in_valid   = 1'b1;
    wait_accept(name, n);
    in_valid   = 1'b0;
    inject_err = 1'b0;
    wait_done(name, lat);
  endtask

  initial begin
    int lat, n, bb, fb, dn;

    // Reset held three cycles.
    repeat (3) tick();
    resetn = 1'b1;
    check("rst ps2_clk",  {31'd0, ps2_clk},  32'd1);
    check("rst ps2_data", {31'd0, ps2_data}, 32'd1);
    check("rst busy",     {31'd0, busy},     32'd0);
    check("rst done",     {31'd0, done},     32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Single byte 0x1C: bits 0,0,0,1,1,1,0,0,0,0,1 on the falling edges.
    bb = rx_bytes.size();
    fb = rx_frames.size();
    send(8'h1C, 1'b0, "1C", lat);
    check("1C latency", lat, 97);
    check("1C frames", rx_frames.size(), fb + 1);
    if (rx_frames.size() > fb) check("1C frame bits", {21'd0, rx_frames[fb]}, 32'h438);
    check("1C bytes", rx_bytes.size(), bb + 1);
    if (rx_bytes.size() > bb) check("1C rx byte", {24'd0, rx_bytes[bb]}, 32'h1C);

    // Back-to-back 0xF0, 0x1C with in_valid held.
    repeat (3) tick();
    bb = rx_bytes.size();
    fb = rx_frames.size();
    in_data  = 8'hF0;
    in_valid = 1'b1;
    wait_accept("F0", n);
    in_data = 8'h1C;
    wait_accept("b2b 1C", n);
    check("b2b accept spacing", n, 97);
    check("b2b accept on done", {31'd0, s_done}, 32'd1);
    in_valid = 1'b0;
    wait_done("b2b 1C", lat);
    check("b2b latency", lat, 97);
    check("b2b bytes", rx_bytes.size(), bb + 2);
    if (rx_frames.size() >= fb + 2) begin
      check("F0 parity", {31'd0, rx_frames[fb][9]}, 32'd1);
      check("1C parity", {31'd0, rx_frames[fb+1][9]}, 32'd0);
    end
    if (rx_bytes.size() >= bb + 2) begin
      check("b2b rx0", {24'd0, rx_bytes[bb]}, 32'hF0);
      check("b2b rx1", {24'd0, rx_bytes[bb+1]}, 32'h1C);
    end

    // Reset during bit 5 of 0x55, then 0x00.
    repeat (2) tick();
    bb = rx_bytes.size();
    fb = rx_frames.size();
    in_data  = 8'h55;
    in_valid = 1'b1;
    wait_accept("55", n);
    in_valid = 1'b0;
    repeat (43) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("abort ps2_clk",  {31'd0, ps2_clk},  32'd1);
    check("abort ps2_data", {31'd0, ps2_data}, 32'd1);
    check("abort busy",     {31'd0, busy},     32'd0);
    dn = 0;
    repeat (110) begin
      tick();
      if (s_done) dn++;
    end
    check("abort no done", dn, 0);
    check("abort no frame", rx_frames.size(), fb);
    send(8'h00, 1'b0, "00", lat);
    check("00 latency", lat, 97);
    check("00 bytes", rx_bytes.size(), bb + 1);
    if (rx_frames.size() > fb) check("00 parity", {31'd0, rx_frames[fb][9]}, 32'd1);
    if (rx_bytes.size() > bb) check("00 rx byte", {24'd0, rx_bytes[bb]}, 32'h00);

    // in_valid pulsed with 0xAA while busy is ignored.
    repeat (2) tick();
    bb = rx_bytes.size();
    in_data  = 8'h5A;
    in_valid = 1'b1;
    wait_accept("5A", n);
    in_valid = 1'b0;
    repeat (20) tick();
    in_data  = 8'hAA;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done("5A", lat);
    check("5A remaining latency", lat, 76);
    repeat (10) tick();
    check("busy pulse bytes", rx_bytes.size(), bb + 1);
    if (rx_bytes.size() > bb) check("5A rx byte", {24'd0, rx_bytes[bb]}, 32'h5A);

`ifdef PS2_TX_PARITY_INJECT_EN
    // Injected parity error: frame arrives with even parity and is rejected.
    bb = rx_bytes.size();
    fb = rx_frames.size();
    send(8'h1C, 1'b1, "inj 1C", lat);
    check("inj latency", lat, 97);
    check("inj bytes", rx_bytes.size(), bb);
    if (rx_frames.size() > fb) check("inj parity", {31'd0, rx_frames[fb][9]}, 32'd1);
    send(8'h1C, 1'b0, "clean 1C", lat);
    check("clean bytes", rx_bytes.size(), bb + 1);
    if (rx_bytes.size() > bb) check("clean rx byte", {24'd0, rx_bytes[bb]}, 32'h1C);
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
